// File: rtl/control_unit.sv
// Hardwired sequencer: two-cycle fetch, then one or two execute cycles
// driving every select/enable input of the ALU system datapath.
module control_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] IROut,
    input  logic [3:0]  flags,
    output logic [3:0]  RegSel_rf,
    output logic [3:0]  ScrSel,
    output logic [2:0]  FunSel3,
    output logic [2:0]  OutASel,
    output logic [2:0]  OutBSel,
    output logic        MuxDSel,
    output logic [4:0]  FunSel5,
    output logic        flag_we,
    output logic [1:0]  MuxASel,
    output logic [1:0]  MuxBSel,
    output logic [1:0]  MuxCSel,
    output logic        LH,
    output logic        write,
    output logic        E,
    output logic [1:0]  FunSel2_dr,
    output logic [2:0]  RegSel_arf,
    output logic [1:0]  FunSel2_arf,
    output logic [1:0]  OutCSel,
    output logic [1:0]  OutDSel,
    output logic        mem_cs,
    output logic        mem_wr,
    output logic        halted,
    output logic        illegal
);

    localparam int unsigned OPW = 6;

    localparam logic [OPW-1:0] OP_BRA = 6'h00;
    localparam logic [OPW-1:0] OP_BNE = 6'h01;
    localparam logic [OPW-1:0] OP_BEQ = 6'h02;
    localparam logic [OPW-1:0] OP_INC = 6'h03;
    localparam logic [OPW-1:0] OP_ADD = 6'h04;
    localparam logic [OPW-1:0] OP_IMM = 6'h05;
    localparam logic [OPW-1:0] OP_HLT = 6'h06;

    typedef enum logic [2:0] {
        T0   = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        T3   = 3'd3,
        HALT = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [OPW-1:0] opcode;
    logic [2:0]     dst, sreg1, sreg2;
    logic [1:0]     rsel;
    logic           s_bit;
    logic           zflag;
    logic           unused_flags;

    assign opcode       = IROut[15:10];
    assign s_bit        = IROut[9];
    assign rsel         = IROut[9:8];
    assign dst          = IROut[8:6];
    assign sreg1        = IROut[5:3];
    assign sreg2        = IROut[2:0];
    assign zflag        = flags[3];
    assign unused_flags = ^flags[2:0];

    // Register code 0..3 maps R1..R4 onto one-hot enable bit3..bit0
    function automatic logic [3:0] rf_onehot(input logic [1:0] r);
        return 4'(4'b1000 >> r);
    endfunction

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= T0;
        else        state <= state_nxt;
    end

    // Next state and control outputs; everything inactive while reset is low
    always_comb begin
        state_nxt   = state;
        RegSel_rf   = 4'b0000;
        ScrSel      = 4'b0000;
        FunSel3     = 3'b000;
        OutASel     = 3'b000;
        OutBSel     = 3'b000;
        MuxDSel     = 1'b0;
        FunSel5     = 5'b00000;
        flag_we     = 1'b0;
        MuxASel     = 2'b00;
        MuxBSel     = 2'b00;
        MuxCSel     = 2'b00;
        LH          = 1'b0;
        write       = 1'b0;
        E           = 1'b0;
        FunSel2_dr  = 2'b00;
        RegSel_arf  = 3'b000;
        FunSel2_arf = 2'b00;
        OutCSel     = 2'b00;
        OutDSel     = 2'b00;
        mem_cs      = 1'b0;
        mem_wr      = 1'b0;
        halted      = 1'b0;
        illegal     = 1'b0;

        if (reset) begin
            case (state)
                T0, T1: begin
                    OutDSel     = 2'b00;
                    mem_cs      = 1'b1;
                    LH          = (state == T1);
                    write       = 1'b1;
                    RegSel_arf  = 3'b100;
                    FunSel2_arf = 2'b01;
                    state_nxt   = (state == T0) ? T1 : T2;
                end
                T2: begin
                    state_nxt = T0;
                    case (opcode)
                        OP_BRA, OP_BNE, OP_BEQ: begin
                            if ((opcode == OP_BRA) ||
                                (opcode == OP_BNE && !zflag) ||
                                (opcode == OP_BEQ &&  zflag)) begin
                                MuxBSel     = 2'b11;
                                RegSel_arf  = 3'b100;
                                FunSel2_arf = 2'b10;
                            end
                        end
                        OP_INC: begin
                            if (dst[2] || sreg1[2]) begin
                                illegal = 1'b1;
                            end else begin
                                OutASel   = sreg1;
                                FunSel5   = 5'b10000;
                                MuxASel   = 2'b00;
                                RegSel_rf = rf_onehot(dst[1:0]);
                                FunSel3   = 3'b010;
                                state_nxt = T3;
                            end
                        end
                        OP_ADD: begin
                            if (dst[2] || sreg1[2] || sreg2[2]) begin
                                illegal = 1'b1;
                            end else begin
                                OutASel   = sreg1;
                                OutBSel   = sreg2;
                                FunSel5   = 5'b10100;
                                MuxASel   = 2'b00;
                                RegSel_rf = rf_onehot(dst[1:0]);
                                FunSel3   = 3'b010;
                                flag_we   = s_bit;
                            end
                        end
                        OP_IMM: begin
                            MuxASel   = 2'b11;
                            RegSel_rf = rf_onehot(rsel);
                            FunSel3   = 3'b010;
                        end
                        OP_HLT: state_nxt = HALT;
                        default: illegal = 1'b1;
                    endcase
                end
                T3: begin
                    RegSel_rf = rf_onehot(dst[1:0]);
                    FunSel3   = 3'b001;
                    flag_we   = s_bit;
                    state_nxt = T0;
                end
                HALT: begin
                    halted    = 1'b1;
                    state_nxt = HALT;
                end
                default: state_nxt = T0;
            endcase
        end
    end

endmodule
